// File: rtl/mole_round_scheduler.sv
// Whack-A-Mole round controller: spawns moles from the LFSR, times them by level, judges hits/misses.
// Optional streak bonus (4th consecutive hit scores +2) is enabled by defining MOLE_STREAK_BONUS_EN.
module mole_round_scheduler #(
  parameter int NUM_HOLES    = 8,
  parameter int UP_TIME_BASE = 1000,
  parameter int UP_TIME_STEP = 125,
  parameter int GAP_TICKS    = 200,
  parameter int LEVEL_STEP   = 10,
  parameter int MAX_LEVEL    = 7,
  parameter int MAX_MISSES   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] sw,
  input  logic [7:0] random,
  output logic [7:0] led,
  output logic [7:0] score,
  output logic [2:0] level,
  output logic [2:0] misses,
  output logic       hit_pulse,
  output logic       game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_SPAWN = 3'd2;
  localparam logic [2:0] S_UP    = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  prev_hole;
  logic [15:0] timer;
  logic [7:0]  sync1, sync2, delayed;
  logic [7:0]  toggle;
  logic [4:0]  unused_random;
  logic [31:0] quot;
  logic [2:0]  level_calc;
  logic [15:0] up_time;
  logic [2:0]  hole_pick;
  logic        hit, wrong, expire;
  logic [1:0]  add;
  logic [8:0]  score_sum;
  logic [7:0]  score_next;
  logic [2:0]  misses_next;

  // Synchroniser flops carry no reset so a held switch never looks like a toggle after rst.
  always_ff @(posedge clk) begin
    sync1   <= sw;
    sync2   <= sync1;
    delayed <= sync2;
  end

  assign toggle        = sync2 ^ delayed;
  assign unused_random = random[7:3];

  always_comb begin
    quot = {24'd0, score} / LEVEL_STEP;
    if (quot + 32'd1 >= MAX_LEVEL) level_calc = 3'(MAX_LEVEL);
    else                           level_calc = 3'(quot + 32'd1);
  end

  assign up_time   = 16'(UP_TIME_BASE - (32'(level) - 32'd1) * UP_TIME_STEP);
  assign hole_pick = (random[2:0] == prev_hole) ? random[2:0] + 3'd1 : random[2:0];

  // In UP the lit LED is exactly 1<<prev_hole, so anything outside it is a wrong switch.
  assign hit    = toggle[prev_hole];
  assign wrong  = |(toggle & ~led);
  assign expire = tick && (timer == 16'd1);

`ifdef MOLE_STREAK_BONUS_EN
  logic [1:0] streak;

  always_ff @(posedge clk) begin
    if (rst)
      streak <= 2'd0;
    else if (state == S_UP && hit)
      streak <= (streak == 2'd3) ? 2'd0 : streak + 2'd1;
    else if (state == S_UP && (wrong || expire))
      streak <= 2'd0;
  end

  assign add = (streak == 2'd3) ? 2'd2 : 2'd1;
`else
  assign add = 2'd1;
`endif

  assign score_sum   = {1'b0, score} + {7'd0, add};
  assign score_next  = score_sum[8] ? 8'hFF : score_sum[7:0];
  assign misses_next = misses + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      led       <= 8'h00;
      score     <= 8'd0;
      level     <= 3'd1;
      misses    <= 3'd0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
      prev_hole <= 3'd0;
      timer     <= 16'd0;
    end else begin
      hit_pulse <= 1'b0;
      level     <= level_calc;
      case (state)
        S_IDLE: begin
          led <= 8'h00;
          if (|toggle) begin
            state <= S_GAP;
            timer <= 16'(GAP_TICKS);
          end
        end
        S_GAP: begin
          led <= 8'h00;
          if (tick) begin
            timer <= timer - 16'd1;
            if (timer == 16'd1) state <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          led       <= 8'b1 << hole_pick;
          prev_hole <= hole_pick;
          timer     <= up_time;
          state     <= S_UP;
        end
        S_UP: begin
          // A hit wins over any simultaneous wrong toggle or expiry.
          if (hit) begin
            score     <= score_next;
            hit_pulse <= 1'b1;
            led       <= 8'h00;
            timer     <= 16'(GAP_TICKS);
            state     <= S_GAP;
          end else if (wrong || expire) begin
            misses <= misses_next;
            if (misses_next == 3'(MAX_MISSES)) begin
              led       <= 8'hFF;
              game_over <= 1'b1;
              state     <= S_OVER;
            end else begin
              led   <= 8'h00;
              timer <= 16'(GAP_TICKS);
              state <= S_GAP;
            end
          end else if (tick) begin
            timer <= timer - 16'd1;
          end
        end
        S_OVER: begin
          led       <= 8'hFF;
          game_over <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Scoreboard bench for mole_round_scheduler: the driver queues expected spawn/hit/miss events,
// a negedge monitor pops and compares them as the DUT produces them. tick is held high (1 tick per clk).
module tb_mole_round_scheduler;

  localparam int GAP      = 200;
  localparam int EV_SPAWN = 0;
  localparam int EV_HIT   = 1;
  localparam int EV_MISS  = 2;

  typedef struct {
    int         kind;
    logic [7:0] led;
    logic [7:0] score;
    logic [2:0] level;
    logic [2:0] misses;
    int         ticks;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic [7:0] sw, random;
  logic [7:0] led, score;
  logic [2:0] level, misses;
  logic       hit_pulse, game_over;

  exp_t       sb[$];
  int         checks = 0;
  int         passed = 0;
  int         exp_score, exp_misses, exp_streak;
  logic [2:0] exp_prev;
  int         tick_count = 0;
  int         last_ticks = 0;
  logic       rst_q = 1'b1;
  logic [7:0] prev_led = 8'h00;
  logic [2:0] prev_misses = 3'd0;

  always #10 clk = ~clk;

  mole_round_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .sw(sw), .random(random),
    .led(led), .score(score), .level(level), .misses(misses),
    .hit_pulse(hit_pulse), .game_over(game_over)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int exp_level();
    int lv = exp_score / 10 + 1;
    return (lv > 7) ? 7 : lv;
  endfunction

  function automatic int up_ticks(input int lv);
    return 1000 - (lv - 1) * 125;
  endfunction

  always @(posedge clk) begin
    rst_q <= rst;
    if (tick) tick_count <= tick_count + 1;
  end

  // Monitor: pops one expectation per observed DUT event.
  task automatic handle_event(input int kind);
    exp_t e;
    int   el = tick_count - last_ticks;
    last_ticks = tick_count;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL unexpected_event: got kind %0d, expected none", kind);
      return;
    end
    e = sb.pop_front();
    check_output("event_kind", kind, e.kind);
    check_output("event_led", int'(led), int'(e.led));
    check_output("event_score", int'(score), int'(e.score));
    check_output("event_misses", int'(misses), int'(e.misses));
    check_output("event_game_over", int'(game_over),
                 (e.kind == EV_MISS && e.misses == 3'd5) ? 1 : 0);
    if (e.kind == EV_SPAWN) check_output("spawn_level", int'(level), int'(e.level));
    if (e.ticks >= 0) check_output("event_ticks", el, e.ticks);
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      last_ticks = tick_count;
    end else begin
      if (hit_pulse) handle_event(EV_HIT);
      if (misses != prev_misses) handle_event(EV_MISS);
      if (led != prev_led && led != 8'h00 && led != 8'hFF) handle_event(EV_SPAWN);
    end
    prev_led    = led;
    prev_misses = misses;
  end

  task automatic wait_for_spawn();
    int n = 0;
    while (led == 8'h00 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (led == 8'h00) begin
      checks++;
      $display("[TB] FAIL spawn_timeout: got led 0, expected a mole within 1000 clk");
    end
  endtask

  task automatic wait_for_clear(input logic [7:0] lit, input int bound);
    int n = 0;
    while (led == lit && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (led == lit) begin
      checks++;
      $display("[TB] FAIL clear_timeout: got led %0h still lit, expected change within %0d clk", lit, bound);
    end
  endtask

  task automatic score_hit();
    int a = 1;
`ifdef MOLE_STREAK_BONUS_EN
    if (exp_streak == 3) begin
      a = 2;
      exp_streak = 0;
    end else begin
      exp_streak++;
    end
`endif
    exp_score = (exp_score + a > 255) ? 255 : exp_score + a;
  endtask

  // action: 0 = hit (lit hole plus extra), 1 = let it time out, 2 = toggle wrong switches in extra
  task automatic apply_stimulus(input logic [7:0] rnd, input int action, input logic [7:0] extra,
                                input int gap_dur);
    logic [2:0] h;
    logic [7:0] lit;
    int         lv;
    exp_t       e;
    random = rnd;
    h = rnd[2:0];
    if (h == exp_prev) h = h + 3'd1;
    exp_prev = h;
    lit = 8'b1 << h;
    lv = exp_level();
    e = '{EV_SPAWN, lit, 8'(exp_score), 3'(lv), 3'(exp_misses), gap_dur};
    sb.push_back(e);
    wait_for_spawn();
    @(negedge clk);
    if (action == 0) begin
      score_hit();
      e = '{EV_HIT, 8'h00, 8'(exp_score), 3'd0, 3'(exp_misses), -1};
      sb.push_back(e);
      sw = sw ^ (lit | extra);
      wait_for_clear(lit, 20);
    end else begin
      exp_misses++;
      exp_streak = 0;
      e = '{EV_MISS, (exp_misses == 5) ? 8'hFF : 8'h00, 8'(exp_score), 3'd0, 3'(exp_misses),
            (action == 1) ? up_ticks(lv) : -1};
      sb.push_back(e);
      if (action == 2) sw = sw ^ (extra & ~lit);
      wait_for_clear(lit, (action == 1) ? 1200 : 20);
    end
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_led"}, int'(led), 0);
    check_output({tag, "_score"}, int'(score), 0);
    check_output({tag, "_level"}, int'(level), 1);
    check_output({tag, "_misses"}, int'(misses), 0);
    check_output({tag, "_hit_pulse"}, int'(hit_pulse), 0);
    check_output({tag, "_game_over"}, int'(game_over), 0);
  endtask

  initial begin
    #(90000 * 20);
    $display("[TB] FAIL watchdog: got no finish, expected end within 90000 clk");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   bad;
    exp_t e;
    sw = 8'h00; random = 8'h00; tick = 1'b1; rst = 1'b1;
    exp_score = 0; exp_misses = 0; exp_streak = 0; exp_prev = 3'd0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (led != 8'h00 || game_over) bad++;
    end
    check_output("idle_stable", bad, 0);

    sw = sw ^ 8'h01;
    apply_stimulus(8'h05, 0, 8'h00, -1);
    apply_stimulus(8'h05, 1, 8'h00, GAP + 1);
    apply_stimulus(8'h02, 0, 8'h40, GAP + 1);
    apply_stimulus(8'h02, 2, 8'h40, GAP + 1);

    for (int i = 0; exp_score < 69; i++) apply_stimulus(8'(i * 3 + 1), 0, 8'h00, GAP + 1);
    apply_stimulus(8'h07, 0, 8'h00, GAP + 1);
    apply_stimulus(8'h01, 1, 8'h00, GAP + 1);

    for (int i = 0; exp_score < 255; i++) apply_stimulus(8'(i * 5 + 2), 0, 8'h00, GAP + 1);
    apply_stimulus(8'h04, 0, 8'h00, GAP + 1);

    apply_stimulus(8'h06, 2, 8'hFF, GAP + 1);
    apply_stimulus(8'h03, 2, 8'h01, GAP + 1);

    sw = sw ^ 8'hFF;
    repeat (300) @(negedge clk);
    check_output("over_led", int'(led), 8'hFF);
    check_output("over_game_over", int'(game_over), 1);
    check_output("over_misses", int'(misses), 5);
    check_output("over_score", int'(score), 255);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rerun_reset");
    rst = 1'b0;
    exp_score = 0; exp_misses = 0; exp_streak = 0; exp_prev = 3'd0;
    repeat (5) @(negedge clk);
    sw = sw ^ 8'h01;
    random = 8'h05;
    e = '{EV_SPAWN, 8'h20, 8'd0, 3'd1, 3'd0, -1};
    sb.push_back(e);
    wait_for_spawn();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_up_reset");
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_output("post_reset_led", int'(led), 0);
    check_output("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
